// File: rtl/uart_block_fifo_bridge.sv
// Circular byte FIFO bridging a UART RX byte stream to a UART TX start/busy handshake,
// with stream or block release. Optional partial-block flush: define UART_FIFO_TIMEOUT_EN.
module uart_block_fifo_bridge #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned DEPTH          = 16,
   parameter int unsigned BLOCK_SIZE     = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mode_block,
   input  logic [DATA_WIDTH-1:0]  rx_data,
   input  logic                   rx_valid,
   output logic [DATA_WIDTH-1:0]  tx_data,
   output logic                   tx_start,
   input  logic                   tx_busy,
   output logic [$clog2(DEPTH):0] level,
   output logic                   full,
   output logic                   empty,
   output logic                   overflow,
   input  logic                   clr_overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || BLOCK_SIZE < 1 || BLOCK_SIZE > DEPTH ||
       TIMEOUT_CYCLES < 1) begin : g_bad_params
      $error("uart_block_fifo_bridge: illegal parameter set");
   end

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACK  = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         credit_q, credit_d;
   logic [PW-1:0]         unrel_q, unrel_d;
   logic [PW-1:0]         level_d;
   logic                  full_d, empty_d;
   logic                  pop, tx_start_d;
   logic                  wr_en, ovf_set;
   logic                  flush;

   // TX handshake: one start per byte, then wait for a full busy rise/fall
   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      pop        = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (credit_q != '0 && !tx_busy) begin
               pop        = 1'b1;
               tx_start_d = 1'b1;
               state_d    = ST_WAIT_ACK;
            end
         end
         ST_WAIT_ACK:  if (tx_busy)  state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: if (!tx_busy) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // A pop frees a slot on the same edge, so a full FIFO can still accept a byte
   always_comb begin
      wr_en    = rx_valid && (!full || pop);
      ovf_set  = rx_valid && !wr_en;
      wr_ptr_d = wr_ptr_q + PW'(wr_en);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      level_d  = wr_ptr_d - rd_ptr_d;
      full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      empty_d  = (wr_ptr_d == rd_ptr_d);

      credit_d = credit_q - PW'(pop);
      unrel_d  = unrel_q + PW'(wr_en);
      if (!mode_block || flush) begin
         credit_d = credit_d + unrel_d;
         unrel_d  = '0;
      end else if (unrel_d >= PW'(BLOCK_SIZE)) begin
         credit_d = credit_d + PW'(BLOCK_SIZE);
         unrel_d  = unrel_d - PW'(BLOCK_SIZE);
      end
   end

`ifdef UART_FIFO_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] idle_cnt_q, idle_cnt_d;

   // Idle time while a partial block is pending; any received byte restarts it
   always_comb begin
      flush      = mode_block && (idle_cnt_q == TW'(TIMEOUT_CYCLES));
      idle_cnt_d = idle_cnt_q + TW'(1);
      if (rx_valid || unrel_q == '0 || flush) idle_cnt_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) idle_cnt_q <= '0;
      else     idle_cnt_q <= idle_cnt_d;
   end
`else
   assign flush = 1'b0;
`endif

   // Storage is not reset; only the pointers define what is valid
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q[AW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         credit_q <= '0;
         unrel_q  <= '0;
         tx_data  <= '0;
         tx_start <= 1'b0;
         level    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         credit_q <= credit_d;
         unrel_q  <= unrel_d;
         tx_start <= tx_start_d;
         level    <= level_d;
         full     <= full_d;
         empty    <= empty_d;
         if (pop) tx_data <= mem[rd_ptr_q[AW-1:0]];
         if (ovf_set)           overflow <= 1'b1;
         else if (clr_overflow) overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_block_fifo_bridge.sv
// Bench for uart_block_fifo_bridge: scoreboard of accepted bytes plus a simple UART TX busy model.
module tb_uart_block_fifo_bridge;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       mode_block = 1'b0;
   logic [7:0] rx_data = '0;
   logic       rx_valid = 1'b0;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy = 1'b0;
   logic [4:0] level;
   logic       full, empty, overflow;
   logic       clr_overflow = 1'b0;

   int checks = 0;
   int failures = 0;

   logic [7:0] exp_q[$];
   bit         m_ovf = 1'b0;
   logic [7:0] last_tx = '0;
   int         n_starts = 0;
   int         busy_cnt = 0;
   int         busy_len = 10;
   bit         rand_busy = 1'b0;
   bit         hold_busy = 1'b0;
   bit         in_flight = 1'b0;
   bit         busy_hi_seen = 1'b0;

   uart_block_fifo_bridge #(
      .DATA_WIDTH(8), .DEPTH(DEPTH), .BLOCK_SIZE(8), .TIMEOUT_CYCLES(50)
   ) dut (
      .clk(clk), .rst(rst), .mode_block(mode_block), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy), .level(level),
      .full(full), .empty(empty), .overflow(overflow), .clr_overflow(clr_overflow)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   // One clock: apply inputs, sample #1 after the edge, update model, drive the TX busy model
   task automatic cycle(input bit v, input logic [7:0] d, input bit clr);
      bit         popped, was_full, old_inflight, bz, dropped;
      logic [7:0] e;
      rx_valid = v; rx_data = d; clr_overflow = clr;
      bz = tx_busy;
      @(posedge clk); #1;
      popped   = tx_start;
      was_full = (exp_q.size() >= DEPTH);
      old_inflight = in_flight;
      if (in_flight && bz) busy_hi_seen = 1'b1;
      else if (in_flight && !bz && busy_hi_seen) in_flight = 1'b0;
      if (popped) begin
         n_starts++;
         checks++;
         if (old_inflight) begin
            failures++;
            $display("FAIL back_to_back: tx_start=%0b while previous byte busy handshake incomplete, required 0", tx_start);
         end
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL spurious_start: tx_start=1 tx_data=%h, required no start (nothing credited)", tx_data);
            last_tx = tx_data;
         end else begin
            e = exp_q.pop_front();
            if (tx_data !== e) begin
               failures++;
               $display("FAIL byte_order: tx_data=%h required %h", tx_data, e);
            end
            last_tx = e;
         end
         in_flight = 1'b1;
         busy_hi_seen = 1'b0;
      end else begin
         checks++;
         if (tx_data !== last_tx) begin
            failures++;
            $display("FAIL tx_data_hold: tx_data=%h required %h", tx_data, last_tx);
         end
      end
      dropped = v && was_full && !popped;
      if (v && !dropped) exp_q.push_back(d);
      if (dropped) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      checks++;
      if (level !== 5'(exp_q.size())) begin
         failures++;
         $display("FAIL level: level=%0d required %0d", level, exp_q.size());
      end
      checks++;
      if (full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0)) begin
         failures++;
         $display("FAIL full_empty: full=%0b empty=%0b required full=%0b empty=%0b",
                  full, empty, exp_q.size() == DEPTH, exp_q.size() == 0);
      end
      checks++;
      if (overflow !== m_ovf) begin
         failures++;
         $display("FAIL overflow: overflow=%0b required %0b", overflow, m_ovf);
      end
      if (popped) busy_cnt = rand_busy ? int'($urandom_range(1, 4)) : busy_len;
      if (hold_busy) tx_busy = 1'b1;
      else if (busy_cnt > 0) begin tx_busy = 1'b1; busy_cnt--; end
      else tx_busy = 1'b0;
      rx_valid = 1'b0; clr_overflow = 1'b0;
   endtask

   task automatic drain(input int max_cyc);
      int i = 0;
      while ((exp_q.size() != 0 || in_flight) && i < max_cyc) begin
         cycle(1'b0, 8'h00, 1'b0);
         i++;
      end
      checks++;
      if (exp_q.size() != 0 || in_flight) begin
         failures++;
         $display("FAIL drain_timeout: %0d bytes still pending after %0d cycles, required 0", exp_q.size(), max_cyc);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ovf = 1'b0; last_tx = '0;
      in_flight = 1'b0; busy_hi_seen = 1'b0; busy_cnt = 0; tx_busy = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (tx_start !== 1'b0 || tx_data !== 8'h00 || level !== 5'd0 || empty !== 1'b1 ||
          full !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_values: start=%0b data=%h level=%0d empty=%0b full=%0b ovf=%0b required 0,00,0,1,0,0",
                  tx_start, tx_data, level, empty, full, overflow);
      end
      rst = 1'b0;
      model_reset();
      repeat (3) cycle(1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_stream();
      int s0;
      mode_block = 1'b0; busy_len = 10; rand_busy = 1'b0;
      s0 = n_starts;
      cycle(1'b1, 8'h41, 1'b0);
      checks++;
      if (n_starts != s0) begin
         failures++;
         $display("FAIL stream_latency_early: starts=%0d required %0d", n_starts - s0, 0);
      end
      cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (n_starts != s0 + 1) begin
         failures++;
         $display("FAIL stream_latency: starts=%0d required %0d one cycle after write", n_starts - s0, 1);
      end
      cycle(1'b1, 8'h42, 1'b0);
      cycle(1'b1, 8'h43, 1'b0);
      drain(200);
      checks++;
      if (n_starts != s0 + 3 || empty !== 1'b1) begin
         failures++;
         $display("FAIL stream_count: starts=%0d empty=%0b required 3 and 1", n_starts - s0, empty);
      end
   endtask

   task automatic test_block();
      int s0;
      mode_block = 1'b1; busy_len = 3;
      s0 = n_starts;
      for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
      repeat (20) cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (n_starts != s0 || level !== 5'd7) begin
         failures++;
         $display("FAIL block_partial: starts=%0d level=%0d required 0 and 7", n_starts - s0, level);
      end
      cycle(1'b1, 8'h87, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (n_starts != s0 + 1) begin
         failures++;
         $display("FAIL block_release: starts=%0d required 1 right after the 8th byte", n_starts - s0);
      end
      drain(300);
      checks++;
      if (n_starts != s0 + 8) begin
         failures++;
         $display("FAIL block_count: starts=%0d required 8", n_starts - s0);
      end
      mode_block = 1'b0;
   endtask

   task automatic test_overflow();
      int s0;
      mode_block = 1'b0; busy_len = 2;
      hold_busy = 1'b1; tx_busy = 1'b1;
      s0 = n_starts;
      for (int i = 0; i < 18; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
      checks++;
      if (full !== 1'b1 || level !== 5'd16 || overflow !== 1'b1 || n_starts != s0) begin
         failures++;
         $display("FAIL overflow_fill: full=%0b level=%0d ovf=%0b starts=%0d required 1,16,1,0",
                  full, level, overflow, n_starts - s0);
      end
      cycle(1'b1, 8'hAA, 1'b1);
      hold_busy = 1'b0; tx_busy = 1'b0;
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b1, 8'hEE, 1'b0);
      drain(400);
      checks++;
      if (n_starts != s0 + 17) begin
         failures++;
         $display("FAIL overflow_drain: starts=%0d required 17", n_starts - s0);
      end
      cycle(1'b0, 8'h00, 1'b1);
      checks++;
      if (overflow !== 1'b0) begin
         failures++;
         $display("FAIL overflow_clear: overflow=%0b required 0", overflow);
      end
   endtask

   task automatic test_wrap_random();
      int n = 0;
      mode_block = 1'b0; rand_busy = 1'b1;
      while (n < 40) begin
         if ($urandom_range(0, 3) != 0) begin
            cycle(1'b1, 8'($urandom), 1'b0);
            n++;
         end else cycle(1'b0, 8'h00, 1'b0);
         checks++;
         if (level > 5'(DEPTH)) begin
            failures++;
            $display("FAIL level_bound: level=%0d required <= %0d", level, DEPTH);
         end
      end
      drain(1000);
      cycle(1'b0, 8'h00, 1'b1);
   endtask

   task automatic test_mode_random();
      rand_busy = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 9) == 0) mode_block = ~mode_block;
         cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 15) == 0));
      end
      mode_block = 1'b0;
      drain(1000);
      cycle(1'b0, 8'h00, 1'b1);
      rand_busy = 1'b0;
   endtask

   task automatic test_reset_mid_op();
      int s0;
      mode_block = 1'b0; busy_len = 50;
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
      repeat (3) cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (level !== 5'd5 || tx_busy !== 1'b1) begin
         failures++;
         $display("FAIL reset_setup: level=%0d busy=%0b required 5 and 1", level, tx_busy);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (tx_start !== 1'b0 || tx_data !== 8'h00 || level !== 5'd0 || empty !== 1'b1 ||
          full !== 1'b0 || overflow !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_op: start=%0b data=%h level=%0d empty=%0b full=%0b ovf=%0b required 0,00,0,1,0,0",
                  tx_start, tx_data, level, empty, full, overflow);
      end
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      busy_len = 3;
      s0 = n_starts;
      repeat (30) cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (n_starts != s0) begin
         failures++;
         $display("FAIL reset_no_start: starts=%0d required 0", n_starts - s0);
      end
      cycle(1'b1, 8'h5A, 1'b0);
      cycle(1'b1, 8'hA5, 1'b0);
      drain(200);
   endtask

   task automatic test_timeout();
      int s0, i;
      mode_block = 1'b1; busy_len = 3;
      s0 = n_starts;
      for (int k = 0; k < 3; k++) cycle(1'b1, 8'(8'hD0 + k), 1'b0);
`ifdef UART_FIFO_TIMEOUT_EN
      i = 0;
      while (n_starts == s0 && i < 150) begin
         cycle(1'b0, 8'h00, 1'b0);
         i++;
      end
      checks++;
      if (i < 45 || i > 60) begin
         failures++;
         $display("FAIL timeout_flush: first start after %0d idle cycles, required about 51", i);
      end
      drain(200);
`else
      i = 0;
      repeat (150) cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (n_starts != s0 || level !== 5'd3) begin
         failures++;
         $display("FAIL no_timeout: starts=%0d level=%0d required 0 and 3", n_starts - s0, level);
      end
      mode_block = 1'b0;
      cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b0, 8'h00, 1'b0);
      checks++;
      if (n_starts != s0 + 1) begin
         failures++;
         $display("FAIL mode_release: starts=%0d required 1 after switching to stream", n_starts - s0);
      end
      drain(200);
`endif
      mode_block = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_block();
      test_overflow();
      test_wrap_random();
      test_mode_random();
      test_reset_mid_op();
      test_timeout();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
